chunked_subtractor: RTL and testbench

Multi-cycle wide-operand subtractor that computes A − B − borrow_in over NUM_CHUNKS cycles. Each cycle it processes one CHUNK_WIDTH-bit slice, least-significant slice first, using a carry-lookahead slice fed with ~B and passing the borrow between cycles in a register. It sits beside the adder datapath as the subtraction unit for operands wider than one lookahead block. Operands are accepted, and results returned, over valid/ready handshakes.

---
 rtl/chunked_subtractor.sv | 129 ++++++++++++
 tb/tb_chunked_subtractor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// Multi-cycle wide subtractor: A - B - borrow_in, one CHUNK_WIDTH slice per cycle.
// Optional signed overflow output when SUB_OVERFLOW_EN is defined.
module chunked_subtractor #(
  parameter int CHUNK_WIDTH = 8,
  parameter int NUM_CHUNKS  = 4,
  localparam int W = CHUNK_WIDTH * NUM_CHUNKS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out,
`ifdef SUB_OVERFLOW_EN
  output logic         overflow,
`endif
  output logic         zero
);

  localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [W-1:0]           r_a;
  logic [W-1:0]           r_b;
  logic [W-1:0]           r_diff;
  logic [KW-1:0]          r_k;
  logic                   r_c;
  logic                   r_zacc;
  logic                   r_borrow;
  logic                   r_zero;
`ifdef SUB_OVERFLOW_EN
  logic                   r_ovf;
`endif

  logic [CHUNK_WIDTH-1:0] w_sa;
  logic [CHUNK_WIDTH-1:0] w_sb;
  logic [CHUNK_WIDTH-1:0] w_g;
  logic [CHUNK_WIDTH-1:0] w_p;
  logic [CHUNK_WIDTH-1:0] w_s;
  logic                   w_cy;
  logic                   w_sz;

  assign w_sa = r_a[r_k*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign w_sb = ~r_b[r_k*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign w_g  = w_sa & w_sb;
  assign w_p  = w_sa ^ w_sb;
  assign w_sz = (w_s == '0);

  // generate/propagate carry chain across the slice
  always_comb begin
    w_cy = r_c;
    w_s  = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_s[i] = w_p[i] ^ w_cy;
      w_cy   = w_g[i] | (w_p[i] & w_cy);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_k      <= '0;
      r_c      <= 1'b0;
      r_zacc   <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_c     <= ~borrow_in;
            r_k     <= '0;
            r_zacc  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_diff[r_k*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_s;
          r_c    <= w_cy;
          r_zacc <= r_zacc & w_sz;
          r_k    <= r_k + 1'b1;
          if (r_k == K_LAST) begin
            r_borrow <= ~w_cy;
            r_zero   <= r_zacc & w_sz;
`ifdef SUB_OVERFLOW_EN
            r_ovf    <= (r_a[W-1] != r_b[W-1]) &
                        (w_s[CHUNK_WIDTH-1] != r_a[W-1]);
`endif
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign zero       = r_zero;
`ifdef SUB_OVERFLOW_EN
  assign overflow   = r_ovf;
`endif

endmodule

// File: tb/tb_chunked_subtractor.sv
// Self-checking bench for chunked_subtractor against an arithmetic model.
// Define SUB_OVERFLOW_EN to also check the overflow output.
module tb_chunked_subtractor;

  localparam int CW = 8;
  localparam int NC = 4;
  localparam int W  = CW * NC;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         borrow_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;
`ifdef SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  chunked_subtractor #(.CHUNK_WIDTH(CW), .NUM_CHUNKS(NC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .borrow_in(borrow_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .borrow_out(borrow_out),
`ifdef SUB_OVERFLOW_EN
    .overflow(overflow),
`endif
    .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
  } res_t;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi);
    res_t   r;
    longint ua, ub, sa, sb, sd;
    ua   = longint'({32'd0, a});
    ub   = longint'({32'd0, b});
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sd   = sa - sb - longint'(bi);
    r.d  = W'(ua - ub - longint'(bi));
    r.bo = (ua < ub + longint'(bi));
    r.z  = (r.d == '0);
    r.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned #1 after a posedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input int stall, input string nm);
    res_t e;
    int   lat;
    e = model(a, b, bi);
    in_valid = 1'b1; op_a = a; op_b = b; borrow_in = bi; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; borrow_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== NC) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, NC);
    end
    n_checks++;
    if (diff !== e.d || borrow_out !== e.bo || zero !== e.z) begin
      n_fail++;
      $display("FAIL %s result: got d=%h b=%b z=%b want d=%h b=%b z=%b",
               nm, diff, borrow_out, zero, e.d, e.bo, e.z);
    end
`ifdef SUB_OVERFLOW_EN
    n_checks++;
    if (overflow !== e.ov) begin
      n_fail++;
      $display("FAIL %s overflow: got %b want %b", nm, overflow, e.ov);
    end
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      tick();
      n_checks++;
      if (!out_valid || in_ready || diff !== e.d || borrow_out !== e.bo ||
          zero !== e.z) begin
        n_fail++;
        $display("FAIL %s hold%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h",
                 nm, i, out_valid, in_ready, diff, e.d);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 ||
        borrow_out !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got r=%b v=%b d=%h b=%b z=%b want 1 0 0 0 0",
               in_ready, out_valid, diff, borrow_out, zero);
    end
`ifdef SUB_OVERFLOW_EN
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset overflow: got %b want 0", overflow);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, "basic");
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, "underflow");
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0, "equal");
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0, "equal_bin");
    run_op(32'h0000_0100, 32'h0000_0001, 1'b1, 0, "cross_chunk");
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, "all_ones");
  endtask

  task automatic test_overflow();
`ifdef SUB_OVERFLOW_EN
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, "ovf_neg");
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ovf_pos");
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, "ovf_none");
`endif
  endtask

  task automatic test_backpressure();
    res_t e;
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 3, "bp");
    // result handshake with in_valid high must not also accept
    e = model(32'h0000_00FF, 32'h0000_0001, 1'b0);
    in_valid = 1'b1; op_a = 32'h0000_00FF; op_b = 32'h1; borrow_in = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (NC) tick();
    out_ready = 1'b1;
    in_valid = 1'b1; op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_valid: got r=%b v=%b want r=1 v=0",
               in_ready, out_valid);
    end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL next_accept: got r=%b want 0", in_ready);
    end
    repeat (NC) tick();
    e = model(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || diff !== e.d) begin
      n_fail++;
      $display("FAIL next_result: got v=%b d=%h want v=1 d=%h",
               out_valid, diff, e.d);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = (i % 5 == 0) ? a : W'($urandom);
      run_op(a, b, 1'($urandom), int'($urandom_range(0, 2)), "rand");
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    res_t q[$];
    int   t_acc[$];
    int   cyc;
    int   done_n;
    out_ready = 1'b1;
    cyc = 0;
    done_n = 0;
    in_valid = 1'b1;
    op_a = $urandom; op_b = $urandom; borrow_in = 1'($urandom);
    while (done_n < 6 && cyc < 200) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(op_a, op_b, borrow_in));
        t_acc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        e = q.pop_front();
        done_n++;
        n_checks++;
        if (diff !== e.d || borrow_out !== e.bo || zero !== e.z) begin
          n_fail++;
          $display("FAIL b2b result: got d=%h b=%b z=%b want d=%h b=%b z=%b",
                   diff, borrow_out, zero, e.d, e.bo, e.z);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      op_a = $urandom; op_b = $urandom; borrow_in = 1'($urandom);
    end
    in_valid = 1'b0;
    n_checks++;
    if (done_n != 6) begin
      n_fail++;
      $display("FAIL b2b timeout: got %0d results want 6", done_n);
    end
    for (int i = 1; i < t_acc.size(); i++) begin
      n_checks++;
      if (t_acc[i] - t_acc[i-1] != NC + 2) begin
        n_fail++;
        $display("FAIL b2b interval: got %0d want %0d",
                 t_acc[i] - t_acc[i-1], NC + 2);
      end
    end
    while (!in_ready && cyc < 300) begin
      tick();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1; op_a = 32'h0000_0009; op_b = 32'h4; borrow_in = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b r=%b d=%h want v=0 r=1 d=0",
               out_valid, in_ready, diff);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (2 * NC + 2) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid discard: got %0d results want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, "post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
